// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the fetch unit: FSM state encoding and reset/step defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam int          PC_STEP_DEFAULT  = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'd0;

    // A branch target must be word aligned; the low two address bits flag a bad target.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return (lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: pipeline control inputs, instruction-memory handshake and the IF/ID register view.
interface pc_fetch_unit_if #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   stall;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   if_id_valid;
    logic [PC_WIDTH-1:0]    if_id_pc;
    logic [INSTR_WIDTH-1:0] if_id_instr;
    logic                   fetch_timeout;
    logic                   align_fault;

    modport master (
        input  stall, branch_taken, branch_target, imem_ready, imem_rdata,
        output imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
               fetch_timeout, align_fault
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_ready, imem_rdata,
        input  imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
               fetch_timeout, align_fault
    );
endinterface

// File: rtl/pc_fetch_unit_pc_adder.sv
// Sequential-PC incrementer; wraps modulo 2^PC_WIDTH. Kept separate so the branch unit can reuse it.
module pc_adder
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 64,
    parameter int PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_next
);

    assign pc_next = pc + PC_WIDTH'(PC_STEP);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter owner and instruction fetch sequencer filling the IF/ID register.
// Optional feature: define PC_ALIGN_CHECK_EN to trap misaligned branch targets (align_fault).
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter int                  PC_STEP     = PC_STEP_DEFAULT,
    parameter int                  MAX_WAIT    = 15
) (
    input  logic            clock,
    input  logic            reset,
    pc_fetch_unit_if.master bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    fetch_state_t           state_r;
    logic [PC_WIDTH-1:0]    pc_r;
    logic [PC_WIDTH-1:0]    pc_next_s;
    logic [WAIT_W-1:0]      wait_cnt_r;
    logic [WAIT_W-1:0]      wait_inc_s;
    logic                   imem_req_r;
    logic                   if_id_valid_r;
    logic [PC_WIDTH-1:0]    if_id_pc_r;
    logic [INSTR_WIDTH-1:0] if_id_instr_r;
    logic                   fetch_timeout_r;
`ifdef PC_ALIGN_CHECK_EN
    logic                   align_fault_r;
`endif

    pc_adder #(
        .PC_WIDTH (PC_WIDTH),
        .PC_STEP  (PC_STEP)
    ) u_pc_adder (
        .pc      (pc_r),
        .pc_next (pc_next_s)
    );

    assign wait_inc_s = wait_cnt_r + WAIT_W'(1);

    // Fetch FSM: priority is reset, then branch, then stall, then memory handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= IDLE;
            pc_r            <= RESET_PC;
            wait_cnt_r      <= '0;
            imem_req_r      <= 1'b0;
            if_id_valid_r   <= 1'b0;
            if_id_pc_r      <= '0;
            if_id_instr_r   <= '0;
            fetch_timeout_r <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_fault_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_r    <= REQ;
                    imem_req_r <= 1'b1;
                end
                REQ, HOLD: begin
                    if (bus.branch_taken) begin
`ifdef PC_ALIGN_CHECK_EN
                        if (is_misaligned(bus.branch_target[1:0])) begin
                            state_r       <= ERR;
                            imem_req_r    <= 1'b0;
                            if_id_valid_r <= 1'b0;
                            align_fault_r <= 1'b1;
                        end else begin
                            state_r       <= REQ;
                            imem_req_r    <= 1'b1;
                            pc_r          <= bus.branch_target;
                            if_id_valid_r <= 1'b0;
                            wait_cnt_r    <= '0;
                        end
`else
                        state_r       <= REQ;
                        imem_req_r    <= 1'b1;
                        pc_r          <= bus.branch_target;
                        if_id_valid_r <= 1'b0;
                        wait_cnt_r    <= '0;
`endif
                    end else if (bus.stall) begin
                        state_r    <= HOLD;
                        imem_req_r <= 1'b0;
                    end else if (state_r == HOLD) begin
                        // Leaving HOLD: no request was outstanding, so nothing is accepted here.
                        state_r    <= REQ;
                        imem_req_r <= 1'b1;
                    end else if (bus.imem_ready) begin
                        if_id_valid_r <= 1'b1;
                        if_id_pc_r    <= pc_r;
                        if_id_instr_r <= bus.imem_rdata;
                        pc_r          <= pc_next_s;
                        wait_cnt_r    <= '0;
                    end else begin
                        if_id_valid_r <= 1'b0;
                        wait_cnt_r    <= wait_inc_s;
                        if (wait_inc_s == WAIT_W'(MAX_WAIT)) begin
                            state_r         <= ERR;
                            imem_req_r      <= 1'b0;
                            fetch_timeout_r <= 1'b1;
                        end else begin
                            state_r <= REQ;
                        end
                    end
                end
                ERR: begin
                    imem_req_r    <= 1'b0;
                    if_id_valid_r <= 1'b0;
                end
                default: begin
                    state_r       <= ERR;
                    imem_req_r    <= 1'b0;
                    if_id_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req      = imem_req_r;
    assign bus.imem_addr     = pc_r;
    assign bus.if_id_valid   = if_id_valid_r;
    assign bus.if_id_pc      = if_id_pc_r;
    assign bus.if_id_instr   = if_id_instr_r;
    assign bus.fetch_timeout = fetch_timeout_r;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.align_fault   = align_fault_r;
`else
    assign bus.align_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, corner sequences, random vs. reference model.
module tb_pc_fetch_unit;

    localparam int PW = 64;
    localparam int IW = 32;
    localparam int MW = 15;

    logic clock = 1'b0;
    logic reset;
    logic reset2;
    always #5 clock = ~clock;

    pc_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();
    pc_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus2 ();

    pc_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(64'd0),
                    .PC_STEP(4), .MAX_WAIT(MW)) dut (
        .clock (clock), .reset (reset), .bus (bus));

    pc_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC),
                    .PC_STEP(4), .MAX_WAIT(MW)) dut_wrap (
        .clock (clock), .reset (reset2), .bus (bus2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, and return at the following negedge.
    task automatic drive(input logic rst, input logic st, input logic br, input logic [63:0] tgt,
                         input logic rdy, input logic [31:0] rd);
        reset             = rst;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.imem_ready    = rdy;
        bus.imem_rdata    = rd;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Reference model: behaviour described as "started / held / dead" conditions.
    logic        m_started, m_held, m_dead;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_to, m_af;
    int          m_wait;

    task automatic model_step(input logic rst, input logic st, input logic br, input logic [63:0] tgt,
                              input logic rdy, input logic [31:0] rd);
        logic [1:0] lo;
        lo = tgt[1:0];
        if (rst) begin
            m_started = 1'b0; m_held = 1'b0; m_dead = 1'b0;
            m_pc = 64'd0; m_ipc = 64'd0; m_instr = 32'd0;
            m_valid = 1'b0; m_to = 1'b0; m_af = 1'b0; m_wait = 0;
        end else if (m_dead) begin
            m_valid = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (br) begin
`ifdef PC_ALIGN_CHECK_EN
            if (lo != 2'b00) begin
                m_af = 1'b1; m_dead = 1'b1; m_valid = 1'b0;
            end else begin
                m_pc = tgt; m_valid = 1'b0; m_wait = 0; m_held = 1'b0;
            end
`else
            m_pc = tgt; m_valid = 1'b0; m_wait = 0; m_held = 1'b0;
`endif
        end else if (st) begin
            m_held = 1'b1;
        end else if (m_held) begin
            m_held = 1'b0;
        end else if (rdy) begin
            m_ipc = m_pc; m_instr = rd; m_valid = 1'b1;
            m_pc = m_pc + 64'd4; m_wait = 0;
        end else begin
            m_valid = 1'b0;
            m_wait++;
            if (m_wait == MW) begin
                m_dead = 1'b1; m_to = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic        rst, st, br;
        logic [63:0] tgt;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_to;
    } vec_t;

    vec_t vecs[18];

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 64'd0;
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0;
        bus2.stall = 1'b0; bus2.branch_taken = 1'b0; bus2.branch_target = 64'd0;
        bus2.imem_ready = 1'b0; bus2.imem_rdata = 32'd0;

        //          rst   st    br    tgt         rdy   rdata          req   addr        v     ipc         instr          to
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'd0,     1'b0, 32'd0,         1'b0, 64'd0,     1'b0, 64'd0,     32'd0,         1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b0, 32'd0,         1'b1, 64'd0,     1'b0, 64'd0,     32'd0,         1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'h8B020020,  1'b1, 64'd4,     1'b1, 64'd0,     32'h8B020020,  1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'h8B020021,  1'b1, 64'd8,     1'b1, 64'd4,     32'h8B020021,  1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'h8B020022,  1'b1, 64'd12,    1'b1, 64'd8,     32'h8B020022,  1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'h8B020023,  1'b1, 64'd16,    1'b1, 64'd12,    32'h8B020023,  1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 64'd0,     1'b1, 32'h0,         1'b0, 64'd0,     1'b0, 64'd0,     32'd0,         1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'hDEAD0000,  1'b1, 64'd0,     1'b0, 64'd0,     32'd0,         1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'h11110000,  1'b1, 64'd4,     1'b1, 64'd0,     32'h11110000,  1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'h11110001,  1'b1, 64'd8,     1'b1, 64'd4,     32'h11110001,  1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 64'd0,     1'b1, 32'hFFFF0000,  1'b0, 64'd8,     1'b1, 64'd4,     32'h11110001,  1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 64'd0,     1'b1, 32'hFFFF0001,  1'b0, 64'd8,     1'b1, 64'd4,     32'h11110001,  1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 64'd0,     1'b0, 32'hFFFF0002,  1'b0, 64'd8,     1'b1, 64'd4,     32'h11110001,  1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'hFFFF0003,  1'b1, 64'd8,     1'b1, 64'd4,     32'h11110001,  1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'h11110002,  1'b1, 64'd12,    1'b1, 64'd8,     32'h11110002,  1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 64'h100,   1'b1, 32'hBADBAD00,  1'b1, 64'h100,   1'b0, 64'd8,     32'h11110002,  1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 64'd0,     1'b1, 32'h11110003,  1'b1, 64'h104,   1'b1, 64'h100,   32'h11110003,  1'b0};
`ifdef PC_ALIGN_CHECK_EN
        vecs[17] = '{1'b0, 1'b0, 1'b1, 64'h102,   1'b0, 32'h0,         1'b0, 64'h104,   1'b0, 64'h100,   32'h11110003,  1'b0};
`else
        vecs[17] = '{1'b0, 1'b0, 1'b1, 64'h102,   1'b0, 32'h0,         1'b1, 64'h102,   1'b0, 64'h100,   32'h11110003,  1'b0};
`endif

        @(negedge clock);
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].rdy, vecs[i].rd);
            chk($sformatf("v%0d_req", i),   {63'd0, bus.imem_req},      {63'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  bus.imem_addr,              vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {63'd0, bus.if_id_valid},   {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_pc", i),    bus.if_id_pc,               vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), {32'd0, bus.if_id_instr},   {32'd0, vecs[i].e_instr});
            chk($sformatf("v%0d_to", i),    {63'd0, bus.fetch_timeout}, {63'd0, vecs[i].e_to});
        end
`ifdef PC_ALIGN_CHECK_EN
        chk("align_fault_set", {63'd0, bus.align_fault}, 64'd1);
`else
        chk("align_fault_off", {63'd0, bus.align_fault}, 64'd0);
`endif

        // Timeout: exactly MAX_WAIT consecutive not-ready cycles trip the sticky flag.
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0);
        for (int n = 1; n <= MW; n++) begin
            drive(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0);
            if (n == MW - 1) begin
                chk("to_before", {63'd0, bus.fetch_timeout}, 64'd0);
                chk("req_before", {63'd0, bus.imem_req}, 64'd1);
            end
        end
        chk("to_set", {63'd0, bus.fetch_timeout}, 64'd1);
        chk("to_req", {63'd0, bus.imem_req}, 64'd0);
        chk("to_addr", bus.imem_addr, 64'd0);
        drive(1'b0, 1'b0, 1'b1, 64'h200, 1'b1, 32'h12345678);
        chk("err_sticky_req", {63'd0, bus.imem_req}, 64'd0);
        chk("err_sticky_to", {63'd0, bus.fetch_timeout}, 64'd1);
        chk("err_no_branch", bus.imem_addr, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0);
        chk("rst_clr_to", {63'd0, bus.fetch_timeout}, 64'd0);
        chk("rst_clr_req", {63'd0, bus.imem_req}, 64'd0);
        chk("rst_clr_pc", bus.imem_addr, 64'd0);

        // Wrap-around instance: one fetch from the top of the address space.
        reset2 = 1'b0;
        @(posedge clock); @(negedge clock);
        bus2.imem_ready = 1'b1; bus2.imem_rdata = 32'hCAFEF00D;
        @(posedge clock); @(negedge clock);
        chk("wrap_addr", bus2.imem_addr, 64'd0);
        chk("wrap_ifpc", bus2.if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_valid", {63'd0, bus2.if_id_valid}, 64'd1);
        bus2.imem_ready = 1'b0;

        // Random stimulus against the reference model.
        model_step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0);
        for (int c = 0; c < 600; c++) begin
            logic        r_rst, r_st, r_br, r_rdy;
            logic [63:0] r_tgt;
            logic [31:0] r_rd;
            r_rst = ($urandom_range(0, 59) == 0);
            r_st  = ($urandom_range(0, 5) == 0);
            r_br  = ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rd  = $urandom;
            r_tgt = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) r_tgt = r_tgt & ~64'd3;
            model_step(r_rst, r_st, r_br, r_tgt, r_rdy, r_rd);
            drive(r_rst, r_st, r_br, r_tgt, r_rdy, r_rd);
            chk("rnd_req",   {63'd0, bus.imem_req},      {63'd0, (m_started && !m_held && !m_dead)});
            chk("rnd_addr",  bus.imem_addr,              m_pc);
            chk("rnd_valid", {63'd0, bus.if_id_valid},   {63'd0, m_valid});
            chk("rnd_pc",    bus.if_id_pc,               m_ipc);
            chk("rnd_instr", {32'd0, bus.if_id_instr},   {32'd0, m_instr});
            chk("rnd_to",    {63'd0, bus.fetch_timeout}, {63'd0, m_to});
            chk("rnd_af",    {63'd0, bus.align_fault},   {63'd0, m_af});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
